mul_sched: RTL and testbench
============================

MUL_SCHED -- requirements
Module: mul_sched

Interface
REQ-001 Parameter: WIDTH, default 16, operand width; product is 2*WIDTH bits.
REQ-002 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: req0  input  1  requester 0 level request; held until gnt0 seen.
REQ-005 Port: a0, b0  input  WIDTH each  requester 0 operands; stable while req0 high and gnt0 low.
REQ-006 Port: req1  input  1  requester 1 level request; same rules as req0.
REQ-007 Port: a1, b1  input  WIDTH each  requester 1 operands.
REQ-008 Port: gnt0, gnt1  output  1 each  one-cycle accept pulse; operands captured.
REQ-009 Port: done0, done1  output  1 each  one-cycle completion pulse for that requester.
REQ-010 Port: m  output  WIDTH  low half of last product (a*b bits WIDTH-1:0).
REQ-011 Port: n  output  WIDTH  high half of last product (bits 2*WIDTH-1:WIDTH).
REQ-012 Port: busy  output  1  high whenever state is not IDLE.

Function
REQ-013 Unsigned product; engine is one shared iterative shift-add multiplier, one multiplier bit per cycle.
REQ-014 FSM states: IDLE, RUN, DONE; all outputs registered (Moore).
REQ-015 IDLE: on an edge with any req high, capture the winner's a/b, clear the 2*WIDTH accumulator, set bit counter to 0, go to RUN; gntX is high for exactly the following cycle.
REQ-016 IDLE with no req: remain IDLE; all pulse outputs low.
REQ-017 Arbitration: round-robin via a 1-bit last-served pointer; on simultaneous req0 and req1 the requester not last served wins; a single requester always wins.
REQ-018 Pointer updates only on a grant; reset value is "last = 1", so req0 wins the first tie.
REQ-019 RUN: each edge, if a[cnt] = 1 then add (b << cnt) to the accumulator; cnt increments; after the edge processing cnt = WIDTH-1, go to DONE.
REQ-020 Accumulator and adder are 2*WIDTH bits wide; no overflow is possible; there is no truncation before the output split.
REQ-021 The edge entering DONE loads m/n from the final accumulator; doneX for the granted requester is high for exactly the DONE cycle.
REQ-022 DONE: the next edge always goes to IDLE; requests are not sampled in RUN or DONE.
REQ-023 Latency: accept edge E0; DONE and valid m/n during the cycle after edge E(WIDTH); earliest next accept at E(WIDTH+2); throughput is one op per WIDTH+2 cycles.
REQ-024 m/n hold their value until the next DONE load; they are not cleared on a new grant.
REQ-025 Requests seen during RUN/DONE wait; a req still high in IDLE is arbitrated normally, including back-to-back ops from the same requester when it is alone.
REQ-026 Operand changes after the accept edge have no effect on the op in flight.
REQ-027 gnt0 and gnt1 are never high together; done0 and done1 are never high together.

Reset
REQ-028 Reset asserted: state=IDLE, cnt=0, accumulator=0, pointer=1, m=0, n=0, gnt0/gnt1/done0/done1=0, busy=0, immediately without waiting for clk.
REQ-029 Reset during RUN/DONE aborts the op; no done pulse is issued for it; the first edge after release behaves as IDLE.

Verification
REQ-030 Single op: req0, a0=0x0003, b0=0x0005 -> gnt0 one cycle after accept; done0 after 16 RUN cycles; m=0x000F, n=0x0000.
REQ-031 Max operands: req1, a1=b1=0xFFFF -> done1; m=0x0001, n=0xFFFE.
REQ-032 Zero operand: a0=0x0000, b0=0x1234 -> m=n=0x0000; also a0=0x1234, b0=0x0000 -> m=n=0x0000; latency is unchanged.
REQ-033 Contention: req0 and req1 high together after reset -> req0 is served first (0x0100*0x0100 -> n=0x0001, m=0x0000); req1 is served next; with both held continuously, grants alternate 0,1,0,1.
REQ-034 Reset mid-RUN: assert reset at cnt=7 -> m=n=0, busy=0, no done; a subsequent req1 op completes correctly.
REQ-035 Operand hold check: change a0 to 0xFFFF one cycle after gnt0 -> result still reflects the captured operands; a scoreboard checks every op against a*b.

Source files
------------

// File: rtl/mul_sched.sv
`default_nettype none
// ==================================================================
// mul_sched: two-requester round-robin front end sharing one
// iterative shift-add unsigned multiplier.  Rev 1.0
// ==================================================================
module mul_sched #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             done0,
  output logic             done1,
  output logic [WIDTH-1:0] m,
  output logic [WIDTH-1:0] n,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] C_CNT_LAST = CW'(WIDTH - 1);

  localparam logic [1:0] C_IDLE = 2'd0;
  localparam logic [1:0] C_RUN  = 2'd1;
  localparam logic [1:0] C_DONE = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic               last_q, last_d;
  logic               owner_q, owner_d;
  logic [WIDTH-1:0]   m_q, m_d;
  logic [WIDTH-1:0]   n_q, n_d;
  logic               gnt0_q, gnt0_d;
  logic               gnt1_q, gnt1_d;
  logic               done0_q, done0_d;
  logic               done1_q, done1_d;
  logic               busy_q, busy_d;

  logic [2*WIDTH-1:0] addend;
  logic [2*WIDTH-1:0] acc_sum;
  logic               pick1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    last_d  = last_q;
    owner_d = owner_q;
    m_d     = m_q;
    n_d     = n_q;
    gnt0_d  = 1'b0;
    gnt1_d  = 1'b0;
    done0_d = 1'b0;
    done1_d = 1'b0;

    addend  = {{WIDTH{1'b0}}, b_q} << cnt_q;
    acc_sum = acc_q + (a_q[cnt_q] ? addend : '0);
    // requester 1 wins when alone, or on a tie when 0 was served last
    pick1   = req1 & (~req0 | ~last_q);

    case (state_q)
      C_IDLE: begin
        if (req0 | req1) begin
          state_d = C_RUN;
          a_d     = pick1 ? a1 : a0;
          b_d     = pick1 ? b1 : b0;
          acc_d   = '0;
          cnt_d   = '0;
          last_d  = pick1;
          owner_d = pick1;
          gnt0_d  = ~pick1;
          gnt1_d  = pick1;
        end
      end
      C_RUN: begin
        acc_d = acc_sum;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == C_CNT_LAST) begin
          state_d = C_DONE;
          cnt_d   = '0;
          m_d     = acc_sum[WIDTH-1:0];
          n_d     = acc_sum[2*WIDTH-1:WIDTH];
          done0_d = ~owner_q;
          done1_d = owner_q;
        end
      end
      C_DONE: begin
        state_d = C_IDLE;
      end
      default: begin
        state_d = C_IDLE;
      end
    endcase

    busy_d = (state_d != C_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= C_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      last_q  <= 1'b1;
      owner_q <= 1'b0;
      m_q     <= '0;
      n_q     <= '0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      last_q  <= last_d;
      owner_q <= owner_d;
      m_q     <= m_d;
      n_q     <= n_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      done0_q <= done0_d;
      done1_q <= done1_d;
      busy_q  <= busy_d;
    end
  end

  assign gnt0  = gnt0_q;
  assign gnt1  = gnt1_q;
  assign done0 = done0_q;
  assign done1 = done1_q;
  assign m     = m_q;
  assign n     = n_q;
  assign busy  = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_mul_sched.sv
`default_nettype none
// ==================================================================
// tb_mul_sched: randomized scoreboard bench for mul_sched.  Rev 1.0
// ==================================================================
module tb_mul_sched;
  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             req0 = 1'b0, req1 = 1'b0;
  logic [WIDTH-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic             gnt0, gnt1, done0, done1, busy;
  logic [WIDTH-1:0] m, n;

  mul_sched #(.WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .a0(a0), .b0(b0),
    .req1(req1), .a1(a1), .b1(b1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .m(m), .n(n), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit                 who;
    logic [2*WIDTH-1:0] prod;
    int                 cyc;
  } exp_t;

  exp_t sb[$];
  exp_t gq[$];

  int n_checks = 0;
  int n_fail   = 0;

  bit               pend[2];
  bit               jg[2];
  logic [WIDTH-1:0] opa[2];
  logic [WIDTH-1:0] opb[2];
  bit               last_m = 1'b1;
  int               next_free = 0;
  int               busy_from = 1, busy_to = 0;
  int               last_e = 0;
  bit               rand_en = 1'b0;
  bit               hold_mode = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic note_fail(input string name, input string what);
    n_checks++;
    n_fail++;
    $display("FAIL %s: %s (cycle %0d)", name, what, cyc);
  endtask

  function automatic logic [WIDTH-1:0] rnd_op();
    case ($urandom_range(7))
      0:       return '0;
      1:       return '1;
      default: return WIDTH'($urandom);
    endcase
  endfunction

  // Scoreboard monitor: checks pulses and busy against the model's queues.
  exp_t mg, md;
  always @(negedge clk) begin
    if (!reset) begin
      if (gnt0 || gnt1) begin
        chk("gnt_exclusive", 64'(gnt0 & gnt1), 64'd0);
        if (gq.size() == 0) note_fail("gnt_unexpected", $sformatf("got gnt0=%b gnt1=%b expected none", gnt0, gnt1));
        else begin
          mg = gq.pop_front();
          chk("gnt_who", 64'(gnt1), 64'(mg.who));
          chk("gnt_cycle", 64'(cyc), 64'(mg.cyc));
        end
      end else if (gq.size() > 0 && gq[0].cyc <= cyc) begin
        mg = gq.pop_front();
        note_fail("gnt_missing", $sformatf("got no grant expected gnt%0d", mg.who));
      end

      if (done0 || done1) begin
        chk("done_exclusive", 64'(done0 & done1), 64'd0);
        if (sb.size() == 0) note_fail("done_unexpected", $sformatf("got done0=%b done1=%b expected none", done0, done1));
        else begin
          md = sb.pop_front();
          chk("done_who", 64'(done1), 64'(md.who));
          chk("done_cycle", 64'(cyc), 64'(md.cyc));
          chk("result_m", 64'(m), 64'(md.prod[WIDTH-1:0]));
          chk("result_n", 64'(n), 64'(md.prod[2*WIDTH-1:WIDTH]));
        end
      end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
        md = sb.pop_front();
        note_fail("done_missing", $sformatf("got no done expected done%0d", md.who));
      end

      chk("busy", 64'(busy), 64'(cyc >= busy_from && cyc <= busy_to));
    end
  end

  // One cycle of stimulus plus the reference model for the coming edge.
  task automatic step();
    int                 e;
    bit                 w;
    exp_t               x;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      if (jg[i]) begin
        if (hold_mode) begin
          opa[i] = rnd_op();
          opb[i] = rnd_op();
        end else begin
          pend[i] = 1'b0;
          opa[i]  = (i == 0) ? '1 : WIDTH'($urandom);
          opb[i]  = WIDTH'($urandom);
        end
      end
    end
    if (rand_en) begin
      for (int i = 0; i < 2; i++) begin
        if (!pend[i] && $urandom_range(3) == 0) begin
          pend[i] = 1'b1;
          opa[i]  = rnd_op();
          opb[i]  = rnd_op();
        end
      end
    end
    req0 = pend[0]; a0 = opa[0]; b0 = opb[0];
    req1 = pend[1]; a1 = opa[1]; b1 = opb[1];
    jg[0] = 1'b0;
    jg[1] = 1'b0;
    e = cyc + 1;
    if (e >= next_free && (pend[0] || pend[1])) begin
      w      = (pend[0] && pend[1]) ? ~last_m : pend[1];
      x.who  = w;
      x.prod = {{WIDTH{1'b0}}, opa[w]} * {{WIDTH{1'b0}}, opb[w]};
      x.cyc  = e + WIDTH;
      sb.push_back(x);
      x.cyc  = e;
      gq.push_back(x);
      last_m    = w;
      next_free = e + WIDTH + 2;
      busy_from = e;
      busy_to   = e + WIDTH;
      last_e    = e;
      jg[w]     = 1'b1;
    end
  endtask

  task automatic issue(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    pend[i] = 1'b1;
    opa[i]  = a;
    opb[i]  = b;
  endtask

  task automatic wait_idle(input int bound);
    int k = 0;
    while ((sb.size() > 0 || gq.size() > 0 || pend[0] || pend[1] || jg[0] || jg[1]) && k < bound) begin
      step();
      k++;
    end
    if (k >= bound) note_fail("wait_idle_timeout", $sformatf("got still busy after %0d cycles expected idle", bound));
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    sb.delete();
    gq.delete();
    pend[0] = 1'b0; pend[1] = 1'b0;
    jg[0] = 1'b0;   jg[1] = 1'b0;
    req0 = 1'b0;    req1 = 1'b0;
    last_m = 1'b1;
    next_free = 0;
    busy_from = 1; busy_to = 0;
    #1;
    chk("rst_m", 64'(m), 64'd0);
    chk("rst_n", 64'(n), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_pulses", 64'({gnt0, gnt1, done0, done1}), 64'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    opa[0] = '0; opb[0] = '0; opa[1] = '0; opb[1] = '0;
    #2;
    apply_reset();

    issue(0, 16'h0003, 16'h0005);
    wait_idle(100);
    issue(1, 16'hFFFF, 16'hFFFF);
    wait_idle(100);

    // Abort an op part way through RUN, then run a clean op on requester 1.
    issue(0, 16'h00FF, 16'h0F0F);
    k = 0;
    while (!jg[0] && k < 10) begin step(); k++; end
    if (!jg[0]) note_fail("midrun_grant_timeout", "got no model grant expected one");
    k = 0;
    while (cyc < last_e + 7 && k < 20) begin step(); k++; end
    apply_reset();
    issue(1, 16'hABCD, 16'h1357);
    wait_idle(100);

    issue(0, 16'h0000, 16'h1234);
    wait_idle(100);
    issue(0, 16'h1234, 16'h0000);
    wait_idle(100);

    // Contention right after reset, both requesters held continuously.
    @(negedge clk);
    apply_reset();
    issue(0, 16'h0100, 16'h0100);
    issue(1, rnd_op(), rnd_op());
    hold_mode = 1'b1;
    repeat (4 * (WIDTH + 2) + 2) step();
    hold_mode = 1'b0;
    wait_idle(200);

    // A lone requester held high gets back-to-back service.
    issue(0, rnd_op(), rnd_op());
    hold_mode = 1'b1;
    repeat (3 * (WIDTH + 2)) step();
    hold_mode = 1'b0;
    wait_idle(200);

    rand_en = 1'b1;
    repeat (900) step();
    rand_en = 1'b0;
    wait_idle(200);
    repeat (3) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
